// File: rtl/dnn_accel_onchip_mem_pipe.sv
// dnn_accel_onchip_mem_pipe
// Single-port Avalon-MM slave on-chip RAM for weight, activation and scratch
// buffers. Configurable width/depth/read latency, readdatavalid/waitrequest
// flow control and a hardware clear engine that fills the array with
// CLEAR_VALUE one word per enabled cycle.
// Optional build macro: ONCHIP_MEM_PERF_CNT_EN adds the rd_count/wr_count
// saturating access counters; without it those ports and counters are absent.
module dnn_accel_onchip_mem_pipe #(
   parameter int                 DATA_W         = 32,
   parameter int                 DEPTH          = 8192,
   parameter int                 ADDR_W         = 13,
   parameter int                 READ_LATENCY   = 1,
   parameter logic [DATA_W-1:0]  CLEAR_VALUE    = '0,
   parameter bit                 CLEAR_ON_RESET = 1'b0,
   // Hex image attached by the vendor memory-initialisation step; an empty
   // string leaves contents undefined until written or cleared.
   parameter string              INIT_FILE      = ""
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clken,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W/8-1:0]   byteenable,
   input  logic                  chipselect,
   input  logic                  read,
   input  logic                  write,
   input  logic [DATA_W-1:0]     writedata,
   output logic [DATA_W-1:0]     readdata,
   output logic                  readdatavalid,
   output logic                  waitrequest,
   input  logic                  clear_req,
   output logic                  clear_busy
`ifdef ONCHIP_MEM_PERF_CNT_EN
   ,
   output logic [31:0]           rd_count,
   output logic [31:0]           wr_count
`endif
);

   localparam int               NB       = DATA_W / 8;
   localparam logic [ADDR_W:0]  LP_DEPTH = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_CLEAR = 2'd2;

   // Control state
   logic [1:0]              r_state;
   logic [ADDR_W-1:0]       r_clr_ptr;
   logic                    r_start_pend;

   // Storage and read pipeline
   logic [DATA_W-1:0]       r_mem [DEPTH];
   logic [DATA_W-1:0]       r_mem_q;
   logic                    r_s0_zero;
   logic [READ_LATENCY-1:0] r_vld;
   logic [DATA_W-1:0]       w_stg_data [READ_LATENCY];

   // Combinational helpers
   logic                    w_in_range;
   logic                    w_waitreq;
   logic                    w_acc;
   logic                    w_acc_rd;
   logic                    w_acc_wr;
   logic                    w_clearing;
   logic                    w_clr_last;
   logic [ADDR_W-1:0]       w_rd_idx;
   logic                    w_mem_we;
   logic [ADDR_W-1:0]       w_mem_addr;
   logic [NB-1:0]           w_mem_be;
   logic [DATA_W-1:0]       w_mem_wdata;

   // Addresses at or beyond DEPTH never touch the array (DEPTH need not be 2^n)
   assign w_in_range = ({1'b0, address} < LP_DEPTH);
   assign w_rd_idx   = w_in_range ? address : '0;

   // Any non-IDLE state, a pending power-on clear or a frozen clock stalls the bus
   assign w_waitreq  = ~clken | (r_state != ST_IDLE) | r_start_pend;

   assign w_acc      = ~reset & clken & chipselect & (read | write) & ~w_waitreq;
   assign w_acc_wr   = w_acc & write;
   // A simultaneous read is dropped in favour of the write
   assign w_acc_rd   = w_acc & read & ~write;

   assign w_clearing = (r_state == ST_CLEAR);
   assign w_clr_last = w_clearing & (r_clr_ptr == LP_LAST);

   // Single write port shared by the clear engine and the bus; the two are
   // mutually exclusive because waitrequest is high throughout CLEAR.
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_addr  = address;
      w_mem_be    = byteenable;
      w_mem_wdata = writedata;
      if (!reset && clken) begin
         if (w_clearing) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_ptr;
            w_mem_be    = '1;
            w_mem_wdata = CLEAR_VALUE;
         end else if (w_acc_wr && w_in_range) begin
            w_mem_we    = 1'b1;
         end
      end
   end

   // Byte-lane write into the array (no reset: contents survive reset)
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int b = 0; b < NB; b++) begin
            if (w_mem_be[b]) begin
               r_mem[w_mem_addr][b*8 +: 8] <= w_mem_wdata[b*8 +: 8];
            end
         end
      end
   end

   // Registered read port: samples the pre-write value at the accept edge
   always_ff @(posedge clk) begin
      if (w_acc_rd) begin
         r_mem_q <= r_mem[w_rd_idx];
      end
   end

   // Stage-0 zero mask: covers out-of-range reads and the reset value of readdata
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s0_zero <= 1'b1;
      end else if (w_acc_rd) begin
         r_s0_zero <= ~w_in_range;
      end
   end

   assign w_stg_data[0] = r_s0_zero ? '0 : r_mem_q;

   // Valid shift register: one bit per read-latency stage, frozen when clken=0
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld <= '0;
      end else if (clken) begin
         r_vld[0] <= w_acc_rd;
         for (int k = 1; k < READ_LATENCY; k++) begin
            r_vld[k] <= r_vld[k-1];
         end
      end
   end

   // Extra data stages for READ_LATENCY > 1; each word moves with its valid
   // bit so readdata holds the last returned word between reads.
   genvar gi;
   generate
      for (gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
         logic [DATA_W-1:0] r_dat;
         // Advance data only when the previous stage holds a valid read
         always_ff @(posedge clk) begin
            if (reset) begin
               r_dat <= '0;
            end else if (clken && r_vld[gi-1]) begin
               r_dat <= w_stg_data[gi-1];
            end
         end
         assign w_stg_data[gi] = r_dat;
      end
   endgenerate

   // Control FSM: IDLE serves the bus, DRAIN lets in-flight reads finish,
   // CLEAR walks the pointer over every word exactly once.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_clr_ptr    <= '0;
         r_start_pend <= CLEAR_ON_RESET;
      end else if (clken) begin
         case (r_state)
            ST_IDLE: begin
               if (clear_req || r_start_pend) begin
                  r_start_pend <= 1'b0;
                  r_clr_ptr    <= '0;
                  // A read accepted this very edge is also in flight
                  r_state      <= (w_acc_rd || (|r_vld)) ? ST_DRAIN : ST_CLEAR;
               end
            end
            ST_DRAIN: begin
               if (~|r_vld) begin
                  r_state <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               if (w_clr_last) begin
                  r_state   <= ST_IDLE;
                  r_clr_ptr <= '0;
               end else begin
                  r_clr_ptr <= r_clr_ptr + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign readdata      = w_stg_data[READ_LATENCY-1];
   assign readdatavalid = r_vld[READ_LATENCY-1] & clken;
   assign waitrequest   = w_waitreq;
   assign clear_busy    = w_clearing;

`ifdef ONCHIP_MEM_PERF_CNT_EN
   logic [31:0] r_rd_count;
   logic [31:0] r_wr_count;

   // Saturating bus-access counters; clear-engine writes are not bus accesses
   always_ff @(posedge clk) begin
      if (reset || (clken && w_clr_last)) begin
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else begin
         if (w_acc_rd && (r_rd_count != 32'hFFFF_FFFF)) begin
            r_rd_count <= r_rd_count + 32'd1;
         end
         if (w_acc_wr && (r_wr_count != 32'hFFFF_FFFF)) begin
            r_wr_count <= r_wr_count + 32'd1;
         end
      end
   end

   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;
`else
   // Access counters compiled out; no extra ports.
`endif

endmodule

// File: tb/tb_dnn_accel_onchip_mem_pipe.sv
// tb_dnn_accel_onchip_mem_pipe
// Directed bench: DEPTH=6 (non power of two), READ_LATENCY=3,
// CLEAR_VALUE=0xA5A5A5A5. Table of single transactions plus hand-written
// sequences for pipelining, stalls, drain/clear and reset mid-clear.
module tb_dnn_accel_onchip_mem_pipe;

   localparam int          DATA_W = 32;
   localparam int          DEPTH  = 6;
   localparam int          ADDR_W = 3;
   localparam int          LAT    = 3;
   localparam logic [31:0] CLR    = 32'hA5A5A5A5;

   logic              clk = 1'b0;
   logic              reset, clken, chipselect, read, write, clear_req;
   logic [ADDR_W-1:0] address;
   logic [3:0]        byteenable;
   logic [31:0]       writedata, readdata;
   logic              readdatavalid, waitrequest, clear_busy;
`ifdef ONCHIP_MEM_PERF_CNT_EN
   logic [31:0]       rd_count, wr_count;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [31:0] rdv_data[$];
   int          rdv_cyc[$];

   typedef struct {
      logic              rd;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [3:0]        be;
      logic [31:0]       wd;
      logic [31:0]       exp;
   } vec_t;

   vec_t vecs[15];

   dnn_accel_onchip_mem_pipe #(
      .DATA_W         (DATA_W),
      .DEPTH          (DEPTH),
      .ADDR_W         (ADDR_W),
      .READ_LATENCY   (LAT),
      .CLEAR_VALUE    (CLR),
      .CLEAR_ON_RESET (1'b0),
      .INIT_FILE      ("")
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .clken         (clken),
      .address       (address),
      .byteenable    (byteenable),
      .chipselect    (chipselect),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .readdata      (readdata),
      .readdatavalid (readdatavalid),
      .waitrequest   (waitrequest),
      .clear_req     (clear_req),
      .clear_busy    (clear_busy)
`ifdef ONCHIP_MEM_PERF_CNT_EN
      ,
      .rd_count      (rd_count),
      .wr_count      (wr_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log every readdatavalid pulse with the cycle it was seen in
   always @(negedge clk) begin
      if (readdatavalid) begin
         rdv_data.push_back(readdata);
         rdv_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      clear_req  = 1'b0;
   endtask

   task automatic bus(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                      input logic [3:0] be, input logic [31:0] wd);
      chipselect = 1'b1;
      read       = rd;
      write      = wr;
      address    = a;
      byteenable = be;
      writedata  = wd;
   endtask

   task automatic flush_log();
      rdv_data.delete();
      rdv_cyc.delete();
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [3:0] be, input logic [31:0] wd);
      bus(1'b0, 1'b1, a, be, wd);
      step();
      idle();
      $display("write addr=%0d be=%h data=%08h", a, be, wd);
   endtask

   // One isolated read: checks acceptance, data and exact latency
   task automatic do_read(input string name, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
      int c0;
      flush_log();
      c0 = cyc;
      bus(1'b1, 1'b0, a, 4'hF, 32'h0);
      @(negedge clk);
      chk({name, "_waitreq"}, {31'b0, waitrequest}, 32'd0);
      step();
      idle();
      repeat (LAT + 3) step();
      chk({name, "_npulse"}, rdv_data.size(), 32'd1);
      if (rdv_data.size() > 0) begin
         chk({name, "_data"}, rdv_data[0], exp);
         chk({name, "_lat"}, rdv_cyc[0] - c0, LAT);
      end
      $display("read  addr=%0d data=%08h expected=%08h", a,
               (rdv_data.size() > 0) ? rdv_data[0] : 32'h0, exp);
   endtask

   initial begin
      int c0;
      int first, last, nbusy, wr_low;

      // {rd, wr, addr, be, wdata, expected read data}
      vecs[0]  = '{1'b0, 1'b1, 3'd5, 4'hF, 32'hDEADBEEF, 32'h0};
      vecs[1]  = '{1'b0, 1'b1, 3'd5, 4'h1, 32'h000000AA, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, 3'd5, 4'hF, 32'h0,        32'hDEADBEAA};
      vecs[3]  = '{1'b0, 1'b1, 3'd1, 4'hF, 32'h11223344, 32'h0};
      vecs[4]  = '{1'b0, 1'b1, 3'd1, 4'h0, 32'hFFFFFFFF, 32'h0};
      vecs[5]  = '{1'b1, 1'b0, 3'd1, 4'hF, 32'h0,        32'h11223344};
      vecs[6]  = '{1'b0, 1'b1, 3'd1, 4'hA, 32'hAABBCCDD, 32'h0};
      vecs[7]  = '{1'b1, 1'b0, 3'd1, 4'hF, 32'h0,        32'hAA22CC44};
      vecs[8]  = '{1'b0, 1'b1, 3'd7, 4'hF, 32'h00000055, 32'h0};
      vecs[9]  = '{1'b1, 1'b0, 3'd7, 4'hF, 32'h0,        32'h00000000};
      vecs[10] = '{1'b1, 1'b0, 3'd1, 4'hF, 32'h0,        32'hAA22CC44};
      vecs[11] = '{1'b1, 1'b1, 3'd2, 4'hF, 32'h12345678, 32'h0};
      vecs[12] = '{1'b1, 1'b0, 3'd2, 4'hF, 32'h0,        32'h12345678};
      vecs[13] = '{1'b0, 1'b1, 3'd0, 4'hF, 32'hCAFEF00D, 32'h0};
      vecs[14] = '{1'b1, 1'b0, 3'd0, 4'hF, 32'h0,        32'hCAFEF00D};

      reset      = 1'b1;
      clken      = 1'b1;
      address    = '0;
      byteenable = '0;
      writedata  = '0;
      idle();
      repeat (3) step();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_rdv", {31'b0, readdatavalid}, 32'd0);
      chk("rst_waitreq", {31'b0, waitrequest}, 32'd0);
      chk("rst_busy", {31'b0, clear_busy}, 32'd0);
`ifdef ONCHIP_MEM_PERF_CNT_EN
      chk("rst_rdcnt", rd_count, 32'd0);
      chk("rst_wrcnt", wr_count, 32'd0);
`endif
      step();

      // Table-driven single transactions
      for (int i = 0; i < 15; i++) begin
         if (vecs[i].rd && vecs[i].wr) begin
            flush_log();
            bus(1'b1, 1'b1, vecs[i].addr, vecs[i].be, vecs[i].wd);
            step();
            idle();
            repeat (LAT + 3) step();
            chk($sformatf("vec%0d_rw_norvd", i), rdv_data.size(), 32'd0);
            $display("rd+wr addr=%0d data=%08h", vecs[i].addr, vecs[i].wd);
         end else if (vecs[i].rd) begin
            do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
         end else begin
            do_write(vecs[i].addr, vecs[i].be, vecs[i].wd);
         end
      end

      // Back-to-back writes then back-to-back reads
      flush_log();
      for (int i = 0; i < 4; i++) begin
         bus(1'b0, 1'b1, ADDR_W'(i), 4'hF, 32'h10 + i);
         @(negedge clk);
         chk($sformatf("b2b_wr%0d_waitreq", i), {31'b0, waitrequest}, 32'd0);
         step();
      end
      c0 = cyc;
      for (int i = 0; i < 4; i++) begin
         bus(1'b1, 1'b0, ADDR_W'(i), 4'hF, 32'h0);
         @(negedge clk);
         chk($sformatf("b2b_rd%0d_waitreq", i), {31'b0, waitrequest}, 32'd0);
         step();
      end
      idle();
      repeat (LAT + 3) step();
      chk("b2b_npulse", rdv_data.size(), 32'd4);
      for (int i = 0; i < rdv_data.size(); i++) begin
         chk($sformatf("b2b_data%0d", i), rdv_data[i], 32'h10 + i);
         chk($sformatf("b2b_cyc%0d", i), rdv_cyc[i] - c0, i + LAT);
         $display("b2b read %0d data=%08h", i, rdv_data[i]);
      end

      // Read then write same address: old data returned
      do_write(3'd4, 4'hF, 32'h44444444);
      flush_log();
      bus(1'b1, 1'b0, 3'd4, 4'hF, 32'h0);
      step();
      bus(1'b0, 1'b1, 3'd4, 4'hF, 32'h99999999);
      step();
      idle();
      repeat (LAT + 3) step();
      chk("rthenw_npulse", rdv_data.size(), 32'd1);
      if (rdv_data.size() > 0) chk("rthenw_data", rdv_data[0], 32'h44444444);
      $display("read-then-write addr=4");
      do_read("rthenw_after", 3'd4, 32'h99999999);

      // Write then read same address: new data returned
      flush_log();
      bus(1'b0, 1'b1, 3'd3, 4'hF, 32'h33333333);
      step();
      bus(1'b1, 1'b0, 3'd3, 4'hF, 32'h0);
      step();
      idle();
      repeat (LAT + 3) step();
      chk("wthenr_npulse", rdv_data.size(), 32'd1);
      if (rdv_data.size() > 0) chk("wthenr_data", rdv_data[0], 32'h33333333);
      $display("write-then-read addr=3");

      // clken low for 4 cycles just as the read would complete
      flush_log();
      c0 = cyc;
      bus(1'b1, 1'b0, 3'd0, 4'hF, 32'h0);
      step();
      idle();
      step();
      step();
      clken = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_waitreq", i), {31'b0, waitrequest}, 32'd1);
         step();
      end
      clken = 1'b1;
      repeat (LAT + 3) step();
      chk("stall_npulse", rdv_data.size(), 32'd1);
      if (rdv_data.size() > 0) begin
         chk("stall_data", rdv_data[0], 32'h10);
         chk("stall_lat", rdv_cyc[0] - c0, LAT + 4);
      end
      $display("stalled read addr=0");

      // Read in flight, then clear_req: drain, then DEPTH busy cycles
      flush_log();
      c0 = cyc;
      bus(1'b1, 1'b0, 3'd5, 4'hF, 32'h0);
      step();
      idle();
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      first  = -1;
      last   = -1;
      nbusy  = 0;
      wr_low = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (clear_busy) begin
            if (first < 0) first = cyc;
            last = cyc;
            nbusy++;
         end
         if (!waitrequest && (first < 0 || clear_busy)) wr_low++;
         if (first >= 0 && !clear_busy) break;
      end
      chk("clr_after_waitreq", {31'b0, waitrequest}, 32'd0);
      step();
      chk("clr_nbusy", nbusy, DEPTH);
      chk("clr_contig", last - first, DEPTH - 1);
      chk("clr_waitreq_low", wr_low, 32'd0);
      chk("clr_rd_npulse", rdv_data.size(), 32'd1);
      if (rdv_data.size() > 0) begin
         chk("clr_rd_data", rdv_data[0], 32'hDEADBEAA);
         chk("clr_rd_lat", rdv_cyc[0] - c0, LAT);
         chk("clr_after_rdv", {31'b0, (first > rdv_cyc[0])}, 32'd1);
      end
      $display("clear with drain: busy cycles=%0d", nbusy);
      for (int a = 0; a < DEPTH; a++) begin
         do_read($sformatf("clrval%0d", a), ADDR_W'(a), CLR);
      end

      // Reset three cycles into a clear
      for (int a = 0; a < 3; a++) do_write(ADDR_W'(a), 4'hF, 32'h11111111 * (a + 1));
      do_write(3'd3, 4'hF, 32'h0BADF00D);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      @(negedge clk);
      chk("mid_busy", {31'b0, clear_busy}, 32'd1);
      step();
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", {31'b0, clear_busy}, 32'd0);
      chk("mid_rst_waitreq", {31'b0, waitrequest}, 32'd0);
      chk("mid_rst_rdv", {31'b0, readdatavalid}, 32'd0);
      chk("mid_rst_readdata", readdata, 32'h0);
      step();
      $display("reset during clear");
      for (int a = 0; a < 3; a++) begin
         do_read($sformatf("mid_clr%0d", a), ADDR_W'(a), CLR);
      end
      do_read("mid_keep3", 3'd3, 32'h0BADF00D);
`ifdef ONCHIP_MEM_PERF_CNT_EN
      chk("end_rdcnt", rd_count, 32'd4);
      chk("end_wrcnt", wr_count, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
